// File: rtl/sqrt_square_if.sv
// rtl/sqrt_square_if.sv - operand/result handshake bundle for the iterative squarer
interface sqrt_square_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0]   dt_i;
   logic               valid_i;
   logic               ready_o;
   logic               busy_o;
   logic [2*WIDTH-1:0] dt_o;
   logic               valid_o;
   logic               ready_i;

   modport slave (
      input  dt_i, valid_i, ready_i,
      output ready_o, busy_o, dt_o, valid_o
   );

   modport master (
      output dt_i, valid_i, ready_i,
      input  ready_o, busy_o, dt_o, valid_o
   );
endinterface

// File: rtl/sqrt_square.sv
// rtl/sqrt_square.sv - iterative shift-add unsigned squarer, one partial product per cycle
module sqrt_square #(
   parameter int WIDTH = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         enb_i,
   sqrt_square_if.slave bus
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH-1:0] r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] r_dt_o;

   logic [2*WIDTH-1:0] w_pp;
   logic [2*WIDTH-1:0] w_acc_next;
   logic               w_last;

   // Partial product for the current multiplier bit and the accumulator it produces
   always_comb begin
      w_pp       = {{WIDTH{1'b0}}, r_mcand} << r_cnt;
      w_acc_next = r_acc + (r_mplier[0] ? w_pp : '0);
      w_last     = (r_cnt == CNT_W'(WIDTH - 1));
   end

   // Control FSM and datapath; enb_i low freezes every register in place
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= S_IDLE;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_dt_o   <= '0;
      end else if (enb_i) begin
         case (r_state)
            S_IDLE: begin
               if (bus.valid_i) begin
                  r_mcand  <= bus.dt_i;
                  r_mplier <= bus.dt_i;
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  r_state  <= S_CALC;
               end
            end
            S_CALC: begin
               r_acc    <= w_acc_next;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
               if (w_last) begin
                  r_dt_o  <= w_acc_next;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               if (bus.ready_i) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Handshake outputs are masked by the enable; busy reports raw occupancy
   always_comb begin
      bus.ready_o = enb_i && (r_state == S_IDLE);
      bus.valid_o = enb_i && (r_state == S_DONE);
      bus.busy_o  = (r_state != S_IDLE);
      bus.dt_o    = r_dt_o;
   end
endmodule
